// File: rtl/roulette_spinner.sv
// Roulette wheel motion generator: constant-rate fast phase, linearly decelerating
// slow phase, then a one-cycle DONE that publishes the stop slot.
module roulette_spinner #(
  parameter int NUM_SLOTS  = 16,
  parameter int FAST_TICKS = 2_500_000,
  parameter int SLOW_INC   = 500_000,
  parameter int FAST_STEPS = 32,
  parameter int SLOW_STEPS = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       spin_active,
  output logic       slowing,
  output logic [3:0] position,
  output logic [3:0] result,
  output logic       result_valid
);

  typedef enum logic [1:0] {IDLE, FAST, SLOW, DONE} state_t;

  localparam logic [23:0] FastTicks = 24'(FAST_TICKS);
  localparam logic [23:0] SlowInc   = 24'(SLOW_INC);
  localparam logic [7:0]  FastSteps = 8'(FAST_STEPS);
  localparam logic [7:0]  SlowSteps = 8'(SLOW_STEPS);
  localparam logic [3:0]  LastSlot  = 4'(NUM_SLOTS - 1);

  state_t      state_q;
  logic [15:0] lfsr_q;
  logic [23:0] tick_q;
  logic [23:0] interval_q;
  logic [7:0]  step_left_q;
  logic [3:0]  position_q;
  logic [3:0]  result_q;
  logic        spin_active_q;
  logic        slowing_q;
  logic        result_valid_q;

  logic [15:0] lfsr_d;
  logic [3:0]  position_d;
  logic [23:0] tick_d;
  logic        step_evt;
  logic        last_step;

  function automatic logic [23:0] sat_add24(input logic [23:0] a, input logic [23:0] b);
    logic [24:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[24] ? 24'hFF_FFFF : sum[23:0];
  endfunction

  // x^16 + x^14 + x^13 + x^11 + 1, shifting toward the MSB
  assign lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  assign position_d = (position_q == LastSlot) ? 4'd0 : position_q + 4'd1;
  assign tick_d     = tick_q + 24'd1;
  assign step_evt   = (tick_q == interval_q - 24'd1);
  assign last_step  = (step_left_q == 8'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      lfsr_q         <= 16'hACE1;
      tick_q         <= 24'd0;
      interval_q     <= FastTicks;
      step_left_q    <= 8'd0;
      position_q     <= 4'd0;
      result_q       <= 4'd0;
      spin_active_q  <= 1'b0;
      slowing_q      <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      lfsr_q         <= lfsr_d;
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            step_left_q   <= FastSteps + {4'd0, lfsr_q[3:0]};
            tick_q        <= 24'd0;
            interval_q    <= FastTicks;
            spin_active_q <= 1'b1;
            state_q       <= FAST;
          end
        end
        FAST, SLOW: begin
          if (step_evt) begin
            position_q <= position_d;
            tick_q     <= 24'd0;
            if (last_step) begin
              if (state_q == FAST) begin
                step_left_q <= SlowSteps;
                interval_q  <= sat_add24(FastTicks, SlowInc);
                slowing_q   <= 1'b1;
                state_q     <= SLOW;
              end else begin
                spin_active_q <= 1'b0;
                slowing_q     <= 1'b0;
                state_q       <= DONE;
              end
            end else begin
              step_left_q <= step_left_q - 8'd1;
              if (state_q == SLOW) begin
                interval_q <= sat_add24(interval_q, SlowInc);
              end
            end
          end else begin
            tick_q <= tick_d;
          end
        end
        DONE: begin
          result_q       <= position_q;
          result_valid_q <= 1'b1;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spin_active  = spin_active_q;
  assign slowing      = slowing_q;
  assign position     = position_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: doc/roulette_spinner.md
# roulette_spinner

Generates the roulette wheel motion for one spin: a fast constant-rate phase, then a decelerating phase, then a stop on a pseudo-random slot. Sits between FSM_Controller and the display/buzzer stages. Its `spin_active` feeds Piezo_Buzzer. Its `position` drives the wheel LEDs/FND. Its `result`/`result_valid` pair feeds the FSM's STOP_RESULT decision.

## Interface
- NUM_SLOTS, 16: slot count, range 2..16; position wraps NUM_SLOTS-1 -> 0.
- FAST_TICKS, 2_500_000: clk cycles per step in the fast phase (50 ms at 50 MHz); must be ≥ 1.
- SLOW_INC, 500_000: interval growth per slow-phase step.
- FAST_STEPS, 32: base fast-phase step count; must be ≥ 1.
- SLOW_STEPS, 12: slow-phase step count; must be ≥ 1.
- clk  in  1  50 MHz system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  spin request, sampled each clk; honoured only in IDLE.
- spin_active  out  1  high while the wheel is moving (FAST or SLOW).
- slowing  out  1  high only in SLOW.
- position  out  4  current wheel slot.
- result  out  4  slot at which the last spin stopped; held until the next stop.
- result_valid  out  1  one-cycle pulse when `result` updates.

## Operation
- LFSR:
  - 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
  - Shifts every clk in all states.
  - Reset seed 16'hACE1; never reaches zero.
- States: IDLE, FAST, SLOW, DONE.
- IDLE:
  - On start=1, latch extra = lfsr[3:0] (0..15).
  - Load step_left = FAST_STEPS + extra, tick_cnt = 0, interval = FAST_TICKS.
  - Go to FAST.
- Step event: occurs when tick_cnt == interval-1.
  - position <= (position == NUM_SLOTS-1) ? 0 : position+1.
  - tick_cnt <= 0 and step_left decrements.
  - Otherwise tick_cnt increments.
- FAST:
  - On the step event where step_left == 1, go to SLOW.
  - Load step_left = SLOW_STEPS and interval = FAST_TICKS + SLOW_INC.
- SLOW:
  - After each step event, interval <= interval + SLOW_INC, saturating at 2^24-1.
  - On the step event where step_left == 1, go to DONE.
- DONE:
  - Lasts one cycle: result <= position, result_valid = 1.
  - Then go to IDLE.
- Outputs: spin_active = (FAST|SLOW); slowing = SLOW.
- Totals per spin:
  - steps = FAST_STEPS + extra + SLOW_STEPS.
  - final position = (start position + steps) mod NUM_SLOTS.
- Widths: tick_cnt and interval are 24 bits; step_left is 8 bits.
- start while FAST/SLOW/DONE is ignored; there is no restart and no queuing.
- position is never reset between spins; each spin continues from where the last stopped.

## Timing
- Reset values:
  - position = 0, result = 0, result_valid = 0, spin_active = 0, slowing = 0.
  - State IDLE, tick_cnt = 0, lfsr = 16'hACE1.
- start high at edge N -> spin_active high from edge N+1.
- First position change occurs FAST_TICKS cycles after entering FAST.
- Each step: position changes on the edge where the step event fires.
- FAST phase lasts FAST_TICKS*(FAST_STEPS+extra) cycles.
- SLOW phase lasts sum over k=1..SLOW_STEPS of (FAST_TICKS + k*SLOW_INC) cycles.
- The final step edge enters DONE:
  - spin_active falls on that edge.
  - result_valid is high the following cycle, with result equal to position.
- A start asserted in that same DONE cycle is ignored. start is accepted from the first IDLE cycle onward.
- Reset asserted mid-spin:
  - All outputs return to reset values immediately (asynchronous).
  - No result_valid is produced.
- start held high continuously: a new spin begins one cycle after each return to IDLE.

## Test plan
Bench parameters for all scenarios: NUM_SLOTS=16, FAST_TICKS=4, SLOW_INC=2, FAST_STEPS=4, SLOW_STEPS=3.

1. Reset then idle 100 cycles -> every output stays at its reset value; position=0.
2. Single start pulse; bench mirrors the LFSR to obtain extra = e. Required response:
   - spin_active high for exactly 4*(4+e)+24 cycles.
   - slowing high for the final 24 of those cycles (intervals 6, 8, 10).
   - result = (7+e) mod 16, with exactly one result_valid pulse.
3. Two back-to-back spins -> the second result equals (first result + 7 + e2) mod 16; position is continuous across the spins.
4. start pulses every cycle during a spin -> spin timing is identical to scenario 2; only one result_valid pulse.
5. Reset asserted mid-SLOW -> outputs clear in the same cycle; result_valid never pulses; the next start behaves as from power-up.
6. NUM_SLOTS=5 with position driven past 4 -> position sequence 3, 4, 0, 1; never exceeds 4.
